// File: rtl/fp_norm_arb.sv
// fp_norm_arb: two-requester normalization controller sharing one 24-bit
// barrel left shifter. Round-robin arbitration, leading-zero count,
// denormal-floor clamp of the shift, registered gnt/done pulses.

// Shared 24-bit barrel left shifter (zero fill).
module left_shifter (
  input  logic [23:0] In,
  input  logic [4:0]  ShAmt,
  output logic [23:0] Out
);
  assign Out = In << ShAmt;
endmodule

// Handshake: a requester raises req with mant/exp stable and holds it until
// it sees its one-cycle gnt pulse (operand captured on the edge that starts
// gnt); req must be dropped by the edge that ends the gnt cycle. Results are
// reported by a one-cycle done pulse; mant_out/exp_out/zero/denorm/done_id
// are valid on done and held until the next done.
module fp_norm_arb #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [MANT_W-1:0] mant0,
  input  logic [MANT_W-1:0] mant1,
  input  logic [EXP_W-1:0]  exp0,
  input  logic [EXP_W-1:0]  exp1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              denorm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             state;
  logic               last_gnt;
  logic               op_id;
  logic [MANT_W-1:0]  op_mant;
  logic [EXP_W-1:0]   op_exp;
  logic [4:0]         shamt;
  logic [EXP_W-1:0]   exp_res;
  logic               zero_res;
  logic               denorm_res;

  logic               winner;
  logic [4:0]         lzc;
  logic [EXP_W-1:0]   lzc_ext;
  logic [4:0]         shamt_n;
  logic [EXP_W-1:0]   exp_n;
  logic               zero_n;
  logic               denorm_n;
  logic [MANT_W-1:0]  sh_out;

  // Round-robin pick: a sole requester always wins; on a tie the one that
  // was not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_gnt;
    else if (req1)    winner = 1'b1;
  end

  // Leading-zero count of the captured mantissa (24 when it is zero).
  always_comb begin
    logic found;
    lzc   = 5'd24;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && op_mant[i]) begin
        lzc   = 5'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign lzc_ext = EXP_W'(lzc);

  // Shift amount and exponent, clamped so the exponent never drops below
  // the denormal floor (a clamped result has exponent field 0, and the
  // shift stops one short of op_exp because denormals use an implied 2^-126).
  always_comb begin
    shamt_n  = 5'd0;
    exp_n    = '0;
    zero_n   = 1'b0;
    denorm_n = 1'b0;
    if (op_mant == '0) begin
      zero_n = 1'b1;
    end else if (op_exp == '0) begin
      denorm_n = 1'b1;
    end else if (lzc_ext >= op_exp) begin
      shamt_n  = 5'(op_exp - 1'b1);
      denorm_n = 1'b1;
    end else begin
      shamt_n = lzc;
      exp_n   = op_exp - lzc_ext;
    end
  end

  left_shifter u_shifter (
    .In    (op_mant),
    .ShAmt (shamt),
    .Out   (sh_out)
  );

  // Controller FSM with all registered outputs; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      op_id      <= 1'b0;
      op_mant    <= '0;
      op_exp     <= '0;
      shamt      <= 5'd0;
      exp_res    <= '0;
      zero_res   <= 1'b0;
      denorm_res <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      mant_out   <= '0;
      exp_out    <= '0;
      zero       <= 1'b0;
      denorm     <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_id    <= winner;
            op_mant  <= winner ? mant1 : mant0;
            op_exp   <= winner ? exp1 : exp0;
            last_gnt <= winner;
            gnt0     <= ~winner;
            gnt1     <= winner;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          shamt      <= shamt_n;
          exp_res    <= exp_n;
          zero_res   <= zero_n;
          denorm_res <= denorm_n;
          state      <= SHIFT;
        end
        SHIFT: begin
          mant_out <= sh_out;
          exp_out  <= exp_res;
          zero     <= zero_res;
          denorm   <= denorm_res;
          done_id  <= op_id;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_arb.sv
// Self-checking bench for fp_norm_arb: directed vectors, expected results
// queued at grant time and compared by a monitor on every done pulse.
module tb_fp_norm_arb;

  localparam int W = 35; // {id, mant[23:0], exp[7:0], zero, denorm}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cycle;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- DUT ----------------
  logic        req0, req1;
  logic [23:0] mant0, mant1;
  logic [7:0]  exp0, exp1;
  logic        gnt0, gnt1, busy, done, done_id, zero, denorm;
  logic [23:0] mant_out;
  logic [7:0]  exp_out;

  fp_norm_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .mant0    (mant0),
    .mant1    (mant1),
    .exp0     (exp0),
    .exp1     (exp1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .mant_out (mant_out),
    .exp_out  (exp_out),
    .zero     (zero),
    .denorm   (denorm)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  bit           rr_phase;
  bit           have_prev;
  int           last_done;
  int           gnt_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic id, input logic [23:0] m,
                                        input logic [7:0] e, input logic z, input logic d);
    return {id, m, e, z, d};
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with id %0d, expected none (cycle %0d)", done_id, cycle);
      end else begin
        e = exp_q.pop_front();
        check("done_id",  {31'd0, done_id}, {31'd0, e[34]});
        check("mant_out", {8'd0, mant_out}, {8'd0, e[33:10]});
        check("exp_out",  {24'd0, exp_out}, {24'd0, e[9:2]});
        check("zero",     {31'd0, zero},    {31'd0, e[1]});
        check("denorm",   {31'd0, denorm},  {31'd0, e[0]});
        if (rr_phase) begin
          if (have_prev) check("rr_done_spacing", cycle - last_done, 3);
          last_done = cycle;
          have_prev = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input logic v, input logic [23:0] m, input logic [7:0] e);
    if (id) begin mant1 = m; exp1 = e; req1 = v; end
    else    begin mant0 = m; exp0 = e; req0 = v; end
  endtask

  // One isolated request: checks gnt at +1 and done at +3 cycles.
  task automatic single_op(input string name, input bit id, input logic [23:0] m,
                           input logic [7:0] e, input logic [W-1:0] expv);
    int n;
    bit got;
    @(negedge clk);
    set_req(id, 1'b1, m, e);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (id ? gnt1 : gnt0) got = 1'b1;
    end
    check({name, "_gnt_latency"}, n, 1);
    if (got) begin
      exp_q.push_back(expv);
      check({name, "_other_gnt"}, {31'd0, id ? gnt0 : gnt1}, 0);
    end
    set_req(id, 1'b0, m, e);
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check({name, "_done_latency"}, n, 3);
    check({name, "_busy_at_done"}, {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  // Round-robin vectors: three per requester, req held between grants.
  logic [23:0]  rr_m[2][3];
  logic [7:0]   rr_e[2][3];
  logic [W-1:0] rr_x[2][3];

  task automatic rr_proc(input bit id);
    int n;
    bit got;
    for (int k = 0; k < 3; k++) begin
      n = 0; got = 1'b0;
      while (!got && n < 30) begin
        @(negedge clk);
        n++;
        if (id ? gnt1 : gnt0) got = 1'b1;
      end
      if (!got) begin
        check("rr_gnt_timeout", 0, 1);
      end else begin
        exp_q.push_back(rr_x[id][k]);
        gnt_log.push_back(int'(id));
        if (k < 2) set_req(id, 1'b1, rr_m[id][k+1], rr_e[id][k+1]);
        else       set_req(id, 1'b0, 24'd0, 8'd0);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit got;
    logic [8:0] seq;
    cycle = 0; checks = 0; errors = 0;
    rr_phase = 1'b0; have_prev = 1'b0; last_done = 0;
    req0 = 1'b0; req1 = 1'b0; mant0 = '0; mant1 = '0; exp0 = '0; exp1 = '0;

    rr_m[0][0] = 24'h400000; rr_e[0][0] = 8'd10;  rr_x[0][0] = pack(0, 24'h800000, 8'd9,   0, 0);
    rr_m[0][1] = 24'h000100; rr_e[0][1] = 8'd20;  rr_x[0][1] = pack(0, 24'h800000, 8'd5,   0, 0);
    rr_m[0][2] = 24'h123456; rr_e[0][2] = 8'd2;   rr_x[0][2] = pack(0, 24'h2468AC, 8'd0,   0, 1);
    rr_m[1][0] = 24'h00FFFF; rr_e[1][0] = 8'd200; rr_x[1][0] = pack(1, 24'hFFFF00, 8'd192, 0, 0);
    rr_m[1][1] = 24'hC00000; rr_e[1][1] = 8'd50;  rr_x[1][1] = pack(1, 24'hC00000, 8'd50,  0, 0);
    rr_m[1][2] = 24'h000000; rr_e[1][2] = 8'd7;   rr_x[1][2] = pack(1, 24'h000000, 8'd0,   1, 0);

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    seq = {gnt0, gnt1, busy, done, done_id, zero, denorm, 2'b00};
    check("reset_flags", {23'd0, seq}, 0);
    check("reset_mant_out", {8'd0, mant_out}, 0);
    check("reset_exp_out", {24'd0, exp_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-op: req0 granted, reset asserted while in CALC
    set_req(0, 1'b1, 24'h123456, 8'd10);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (gnt0) got = 1'b1;
    end
    check("midop_gnt0", {31'd0, got}, 1);
    check("midop_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    seq = {gnt0, gnt1, busy, done, done_id, zero, denorm, 2'b00};
    check("midop_async_flags", {23'd0, seq}, 0);
    check("midop_async_mant", {8'd0, mant_out}, 0);
    @(negedge clk);
    set_req(0, 1'b0, 24'd0, 8'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    single_op("after_reset_req1", 1, 24'h000F00, 8'd40, pack(1, 24'hF00000, 8'd28, 0, 0));

    // Directed normalization cases
    single_op("basic",        0, 24'h000001, 8'd30,  pack(0, 24'h800000, 8'd7, 0, 0));
    single_op("denorm_clamp", 1, 24'h0F0000, 8'd3,   pack(1, 24'h3C0000, 8'd0, 0, 1));
    single_op("zero_mant",    0, 24'h000000, 8'd100, pack(0, 24'h000000, 8'd0, 1, 0));
    single_op("zero_exp",     1, 24'h400000, 8'd0,   pack(1, 24'h400000, 8'd0, 0, 1));
    single_op("passthrough",  0, 24'h800000, 8'd1,   pack(0, 24'h800000, 8'd1, 0, 0));
    single_op("lzc_eq_exp",   1, 24'h0F0000, 8'd4,   pack(1, 24'h780000, 8'd0, 0, 1));
    single_op("lzc_lt_exp",   0, 24'h0F0000, 8'd5,   pack(0, 24'hF00000, 8'd1, 0, 0));

    // Round-robin: both requesting from reset
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b1, rr_m[0][0], rr_e[0][0]);
    set_req(1, 1'b1, rr_m[1][0], rr_e[1][0]);
    @(negedge clk);
    rst_n = 1'b1;
    rr_phase = 1'b1;
    fork
      rr_proc(0);
      rr_proc(1);
    join
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rr_phase = 1'b0;
    check("rr_grant_count", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_log.size()) check("rr_grant_order", gnt_log[i], i % 2);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_arb.md
# fp_norm_arb

Two-requester normalization controller for the FP datapath's single 24-bit barrel left shifter. It accepts {exponent, mantissa} from two requesters (e.g. adder and multiplier post-processing) and arbitrates round-robin. It computes the leading-zero count, clamps the shift so the exponent never goes below the denormal floor, and drives one internal instance of the team's 24-bit `left_shifter` (24-bit `In`, 5-bit `ShAmt`). The normalized result is returned with a registered done pulse.

## Interface
- MANT_W, 24, mantissa width; fixed, matches the shifter.
- EXP_W, 8, exponent width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req0 / req1  in  1  request level; held by the requester until its grant.
- mant0 / mant1  in  24  mantissa; must be stable while req is high.
- exp0 / exp1  in  8  biased exponent; must be stable while req is high.
- gnt0 / gnt1  out  1  one-cycle registered pulse; operand captured.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle registered pulse; result outputs valid.
- done_id  out  1  requester index of the result on `done`.
- mant_out  out  24  normalized mantissa; held until the next done.
- exp_out  out  8  adjusted exponent; held until the next done.
- zero  out  1  input mantissa was 0.
- denorm  out  1  result is denormal (exp_out = 0, bit 23 may be 0).

## Operation
- FSM has three states: IDLE, CALC, SHIFT.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner and capture its mant/exp into op regs at the edge.
  - Set the winner's gnt for the next cycle and move to CALC.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester ≠ last_gnt wins.
  - last_gnt updates on every grant. It resets to 1, so requester 0 wins the first tie.
- CALC:
  - lzc = count of leading zeros of op_mant, range 0..24.
  - Shift amount is registered as follows, then the FSM moves to SHIFT:
    - op_mant = 0: shamt = 0, exp_res = 0, zero = 1, denorm = 0.
    - op_exp = 0: shamt = 0, exp_res = 0, denorm = 1.
    - lzc ≥ op_exp: shamt = op_exp − 1, exp_res = 0, denorm = 1.
    - Otherwise: shamt = lzc, exp_res = op_exp − lzc, denorm = 0.
  - Non-zero mantissa gives shamt ≤ 23. The shifter's ShAmt values 24–31 are never driven.
- SHIFT:
  - The shifter sees In = op_mant and ShAmt = shamt.
  - Registered at the edge: mant_out ← shifter Out; exp_out, zero, denorm, done_id ← the CALC results / captured index; done ← 1.
  - Return to IDLE.
- done, gnt0 and gnt1 are cleared every cycle unless set as above.
- Result registers change only on the SHIFT edge.
- Reset mid-operation: the in-flight op is dropped and the FSM goes to IDLE. All outputs return to 0 and last_gnt to 1. No done is issued for the dropped op.

## Timing
- Reset values: every output is 0 (gnt0, gnt1, busy, done, done_id, mant_out, exp_out, zero, denorm).
- req sampled high in IDLE at edge E0:
  - gnt high during cycle E0..E1.
  - done high during cycle E2..E3.
  - Latency is 3 edges from the accepting edge to the done cycle.
- IDLE is re-entered at E2. A req present in cycle E2..E3 is accepted at E3.
  - Peak throughput is one op per 3 cycles.
- The requester must drop req by the edge ending its gnt cycle. Any req still high when IDLE is re-entered counts as a new request.
- A req arriving while busy waits, with no loss, until IDLE.
- mant/exp of a non-winning requester are not sampled.
- Each requester's mant/exp must be stable from when it raises req until its own grant is issued.

## Test plan
- Reset mid-op:
  - Stimulus: assert rst_n = 0 in the CALC state with req0 pending.
  - Required: all outputs go to 0 immediately (asynchronously), with no done after release.
  - Then: a single req1 is granted to requester 1, i.e. last_gnt reset does not block a sole requester.
- Basic normalization:
  - Stimulus: req0, mant0 = 0x000001, exp0 = 30.
  - Required: gnt0 at +1 cycle; done at +3 cycles with mant_out = 0x800000, exp_out = 7, done_id = 0, zero = 0, denorm = 0.
- Denormal clamp:
  - Stimulus: req1, mant1 = 0x0F0000, exp1 = 3.
  - Required: mant_out = 0x3C0000, exp_out = 0, denorm = 1, done_id = 1.
- Zero and exp-zero:
  - Stimulus A: mant = 0, exp = 100. Required: mant_out = 0, exp_out = 0, zero = 1.
  - Stimulus B: mant = 0x400000, exp = 0. Required: mant_out = 0x400000, exp_out = 0, denorm = 1.
- Round-robin fairness:
  - Stimulus: req0 and req1 held continuously from reset; each requester re-raises immediately after its gnt.
  - Required: grants alternate 0, 1, 0, 1; one done every 3 cycles.
- Already-normal passthrough:
  - Stimulus: mant = 0x800000, exp = 1.
  - Required: shamt = 0, mant_out = 0x800000, exp_out = 1, denorm = 0.
